// File: rtl/calc_pkg.sv
// Shared calculator types: BCD digit width/type and the binary-to-BCD converter states.
package calc_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } b2b_state_t;

endpackage : calc_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the next left shift carries into
// the next decimal place.
module bcd_add3
  import calc_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  // Valid inputs are 0..9, so the 4-bit sum never needs a carry out.
  assign adjusted = (digit >= bcd_digit_t'(5)) ? bcd_digit_t'(digit + bcd_digit_t'(3)) : digit;

endmodule : bcd_add3

// File: rtl/bin_to_bcd_converter.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3) with sign handling and valid/ready on both sides.
// Optional leading-zero blank mask is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bin_to_bcd_converter
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             i_data,
  input  logic                              i_2s_comp,
  input  logic                              i_valid,
  output logic                              o_ready,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] o_bcd,
  output logic                              o_negative,
  output logic [NUM_DIGITS-1:0]             o_blank,
  output logic                              o_valid,
  input  logic                              i_ready
);

  localparam int BCD_W = BCD_DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // The digit count must be able to hold every DATA_WIDTH-bit magnitude.
  if ((64'(10) ** NUM_DIGITS) <= (64'(1) << DATA_WIDTH)) begin : g_range_check
    $error("bin_to_bcd_converter: NUM_DIGITS too small for DATA_WIDTH");
  end

  b2b_state_t state, state_next;

  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] bin_q;
  logic [BCD_W-1:0]      work_q;
  logic [BCD_W-1:0]      work_adj;
  logic [BCD_W-1:0]      work_next;
  logic [BCD_W-1:0]      bcd_q;
  logic                  sign_q;

  logic                  accept;
  logic                  last_iter;
  logic                  neg_in;
  logic [DATA_WIDTH-1:0] mag_in;

  assign accept    = (state == IDLE) && i_valid;
  assign last_iter = (state == CONVERT) && (count == CNT_W'(DATA_WIDTH - 1));

  // Negating the most negative value wraps back to itself, which read unsigned is the right magnitude.
  assign neg_in = i_2s_comp & i_data[DATA_WIDTH-1];
  assign mag_in = neg_in ? (~i_data + DATA_WIDTH'(1)) : i_data;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_add3 u_add3 (
      .digit    (work_q[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (work_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign work_next = {work_adj[BCD_W-2:0], bin_q[DATA_WIDTH-1]};

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (i_valid)   state_next = CONVERT;
      CONVERT: if (last_iter) state_next = DONE;
      DONE:    if (i_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      bin_q  <= '0;
      work_q <= '0;
      bcd_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      if (accept) begin
        count  <= '0;
        bin_q  <= mag_in;
        work_q <= '0;
        sign_q <= neg_in;
      end else if (state == CONVERT) begin
        count  <= count + CNT_W'(1);
        bin_q  <= bin_q << 1;
        work_q <= work_next;
      end
      // The visible result changes only when a conversion completes, so it is stable throughout DONE.
      if (last_iter) bcd_q <= work_next;
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_q;
  logic [NUM_DIGITS-1:0] blank_next;
  logic                  upper_zero;

  // Scan from the top digit down; digit 0 is never blanked so a zero result still shows one '0'.
  always_comb begin
    blank_next = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero    = upper_zero && (work_next[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_next[k] = upper_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            blank_q <= '0;
    else if (last_iter) blank_q <= blank_next;
  end

  assign o_blank = blank_q;
`else
  assign o_blank = '0;
`endif

  assign o_ready    = (state == IDLE);
  assign o_valid    = (state == DONE);
  assign o_bcd      = bcd_q;
  assign o_negative = sign_q;

endmodule : bin_to_bcd_converter

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter: directed vector table, backpressure and reset
// sequences, and random values compared against an arithmetic decimal model.
module tb_bin_to_bcd_converter;

  localparam int DW = 16;
  localparam int ND = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_data;
  logic          i_2s_comp;
  logic          i_valid;
  logic          o_ready;
  logic [4*ND-1:0] o_bcd;
  logic          o_negative;
  logic [ND-1:0] o_blank;
  logic          o_valid;
  logic          i_ready;

  int vectors = 0;
  int miscompares = 0;

  bin_to_bcd_converter #(.DATA_WIDTH(DW), .NUM_DIGITS(ND)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_2s_comp  (i_2s_comp),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_bcd      (o_bcd),
    .o_negative (o_negative),
    .o_blank    (o_blank),
    .o_valid    (o_valid),
    .i_ready    (i_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]   data;
    logic            comp;
    logic [4*ND-1:0] bcd;
    logic            neg;
    logic [ND-1:0]   blank;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int ref_mag(input logic [DW-1:0] d, input logic c);
    int v;
    v = int'(d);
    return (c && d[DW-1]) ? (65536 - v) : v;
  endfunction

  function automatic logic [4*ND-1:0] ref_bcd(input int mag);
    logic [4*ND-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'((mag / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // A digit is blanked when the whole value is below its place weight; digit 0 never is.
  function automatic logic [ND-1:0] ref_blank(input int mag);
    logic [ND-1:0] r;
    int p;
    r = '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    p = 10;
    for (int k = 1; k < ND; k++) begin
      r[k] = (mag < p);
      p = p * 10;
    end
`else
    p = mag;
`endif
    return r;
  endfunction

  function automatic logic [ND-1:0] tbl_blank(input logic [ND-1:0] b);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    return b;
`else
    return (b & '0);
`endif
  endfunction

  task automatic convert(input string name, input logic [DW-1:0] d, input logic c,
                         input logic [4*ND-1:0] e_bcd, input logic e_neg, input logic [ND-1:0] e_blank,
                         input int hold, input logic spurious);
    int n;
    n = 0;
    while (!o_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " ready"}, 64'(o_ready), 64'(1));
    i_data    = d;
    i_2s_comp = c;
    i_valid   = 1'b1;
    i_ready   = (hold == 0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    n = 1;
    while (!o_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(DW + 1));
    check({name, " bcd"}, 64'(o_bcd), 64'(e_bcd));
    check({name, " neg"}, 64'(o_negative), 64'(e_neg));
    check({name, " blank"}, 64'(o_blank), 64'(e_blank));
    check({name, " busy"}, 64'(o_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      if (spurious) begin
        i_valid   = 1'b1;
        i_data    = ~d;
        i_2s_comp = ~c;
      end
      @(posedge clk); #1;
      check({name, " hold"}, 64'({o_valid, o_ready, o_negative, o_blank, o_bcd}),
            64'({1'b1, 1'b0, e_neg, e_blank, e_bcd}));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " release"}, 64'({o_valid, o_ready}), 64'(2'b01));
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{16'd12345, 1'b0, 20'h12345, 1'b0, 5'b00000};
    tbl[1] = '{16'hFFFF,  1'b1, 20'h00001, 1'b1, 5'b11110};
    tbl[2] = '{16'hFFFF,  1'b0, 20'h65535, 1'b0, 5'b00000};
    tbl[3] = '{16'h8000,  1'b1, 20'h32768, 1'b1, 5'b00000};
    tbl[4] = '{16'h0000,  1'b1, 20'h00000, 1'b0, 5'b11110};
    tbl[5] = '{16'd42,    1'b0, 20'h00042, 1'b0, 5'b11100};
    tbl[6] = '{16'h7FFF,  1'b1, 20'h32767, 1'b0, 5'b00000};

    rst       = 1'b1;
    i_data    = '0;
    i_2s_comp = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset state", 64'({o_ready, o_valid, o_negative, o_blank, o_bcd}), 64'({1'b1, 1'b0, 1'b0, 5'b0, 20'h0}));

    for (int i = 0; i < 7; i++)
      convert($sformatf("table[%0d]", i), tbl[i].data, tbl[i].comp, tbl[i].bcd, tbl[i].neg,
              tbl_blank(tbl[i].blank), 0, 1'b0);

    // Ten cycles of downstream stall with conflicting upstream traffic.
    convert("backpressure", 16'd12345, 1'b0, 20'h12345, 1'b0, tbl_blank(5'b00000), 10, 1'b1);
    check("no re-accept", 64'(o_valid), 64'(0));

    // Reset in the fifth CONVERT cycle discards the in-flight result.
    i_data    = 16'd999;
    i_2s_comp = 1'b0;
    i_valid   = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid-convert reset", 64'({o_ready, o_valid, o_bcd}), 64'({1'b1, 1'b0, 20'h0}));
    convert("after reset", 16'd7, 1'b0, 20'h00007, 1'b0, tbl_blank(5'b11110), 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [DW-1:0] d;
      logic c;
      int mag;
      d   = DW'($urandom_range(0, 65535));
      c   = 1'($urandom_range(0, 1));
      mag = ref_mag(d, c);
      convert($sformatf("random[%0d]", i), d, c, ref_bcd(mag), (c && d[DW-1]), ref_blank(mag),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bin_to_bcd_converter
